register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 92 +++++++++
 tb/tb_register_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Register file with two combinational read ports and one clocked write port; register 0 is hard-wired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] readRegA,
    input  logic [ADDR_WIDTH-1:0] readRegB,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  r_wr_ok;
    logic                  w_we;

    // An unknown regWrite propagates to w_we and is then rejected by the if below.
    assign w_we = r_wr_ok & regWrite & (writeReg != ZERO_ADDR);

    // Write permission: held off during reset and for the edge on which reset is released.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wr_ok <= 1'b0;
        end else begin
            r_wr_ok <= 1'b1;
        end
    end

    // Register storage: asynchronous clear, single write port.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= ZERO_DATA;
            end
        end else if (w_we) begin
            r_regs[writeReg] <= writeData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;

    // Forwarding is qualified on a non-zero target, so address 0 can never be forwarded.
    assign w_fwd = resetN & regWrite & (writeReg != ZERO_ADDR);

    // Read ports: zero register, then storage, overridden by in-flight write data.
    always_comb begin
        readDataA = ZERO_DATA;
        readDataB = ZERO_DATA;
        if (w_fwd && (readRegA == writeReg)) begin
            readDataA = writeData;
        end else if (readRegA != ZERO_ADDR) begin
            readDataA = r_regs[readRegA];
        end else begin
            readDataA = ZERO_DATA;
        end
        if (w_fwd && (readRegB == writeReg)) begin
            readDataB = writeData;
        end else if (readRegB != ZERO_ADDR) begin
            readDataB = r_regs[readRegB];
        end else begin
            readDataB = ZERO_DATA;
        end
    end
`else
    // Read ports: zero register, otherwise the stored (pre-edge) value.
    always_comb begin
        readDataA = ZERO_DATA;
        readDataB = ZERO_DATA;
        if (readRegA != ZERO_ADDR) begin
            readDataA = r_regs[readRegA];
        end else begin
            readDataA = ZERO_DATA;
        end
        if (readRegB != ZERO_ADDR) begin
            readDataB = r_regs[readRegB];
        end else begin
            readDataB = ZERO_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model,
// plus directed scenarios with literal expectations.
module tb_register_file;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [4:0]  readRegA = 5'd0;
    logic [4:0]  readRegB = 5'd0;
    logic [4:0]  writeReg = 5'd0;
    logic [31:0] writeData = 32'd0;
    logic        regWrite = 1'b0;
    logic [31:0] readDataA;
    logic [31:0] readDataB;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    bit  allowed = 1'b0;
    bit [31:0] mdl [32];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .resetN(resetN),
        .readRegA(readRegA), .readRegB(readRegB),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readDataA(readDataA), .readDataB(readDataB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what a read port must show given the model contents and current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (resetN && regWrite === 1'b1 && writeReg != 5'd0 && a == writeReg) return writeData;
`endif
        return mdl[a];
    endfunction

    // Model update: reset clears all; writes are refused on the edge that releases reset.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            foreach (mdl[i]) mdl[i] = 32'd0;
            allowed = 1'b0;
        end else begin
            if (allowed && regWrite === 1'b1 && writeReg != 5'd0) mdl[writeReg] = writeData;
            allowed = 1'b1;
        end
    end

    // Compare both ports against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("portA", readDataA, exp_rd(readRegA));
            chk("portB", readDataB, exp_rd(readRegB));
        end
    end

    task automatic drive(input logic [4:0] wa, input logic [31:0] wd, input logic we,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        #2;
        writeReg = wa; writeData = wd; regWrite = we; readRegA = ra; readRegB = rb;
    endtask

    initial begin
        logic [4:0] wa;
        #1 resetN = 1'b0;
        chk_en = 1'b1;
        // Reset released coincident with a clock edge while a write is requested.
        writeReg = 5'd4; writeData = 32'h0000_0044; regWrite = 1'b1;
        @(negedge clk);
        @(posedge clk);
        resetN = 1'b1;
        drive(5'd0, 32'd0, 1'b0, 5'd4, 5'd0);
        #1 chk("coincident_release", readDataA, 32'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        // Async reset mid-cycle after preloading reg 5.
        drive(5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
        #1 chk("preload5", readDataA, 32'hDEAD_BEEF);
        #1 resetN = 1'b0;
        #1 chk("async_reset5", readDataA, 32'd0);
        chk("async_reset5_b", readDataB, 32'd0);
        @(negedge clk);
        #2 resetN = 1'b1;

        // Basic write/read.
        drive(5'd7, 32'h1234_5678, 1'b1, 5'd0, 5'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
        #1 chk("wr7_a", readDataA, 32'h1234_5678);
        chk("wr7_b", readDataB, 32'h1234_5678);
        drive(5'd0, 32'd0, 1'b0, 5'd6, 5'd8);
        #1 chk("other6", readDataA, 32'd0);
        chk("other8", readDataB, 32'd0);

        // Register 0 write ignored.
        drive(5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        #1 chk("reg0_pre", readDataA, 32'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        #1 chk("reg0_post", readDataA, 32'd0);

        // Write enable low.
        drive(5'd3, 32'hAAAA_5555, 1'b0, 5'd3, 5'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
        #1 chk("we_low", readDataA, 32'd0);

        // Unknown write enable.
        drive(5'd11, 32'h0000_0099, 1'bx, 5'd0, 5'd0);
        drive(5'd0, 32'd0, 1'b0, 5'd11, 5'd0);
        #1 chk("we_x", readDataA, 32'd0);

        // Same-cycle read of the write target.
        drive(5'd9, 32'h0000_0001, 1'b1, 5'd0, 5'd0);
        drive(5'd9, 32'h0000_BEEF, 1'b1, 5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        #1 chk("same_cycle", readDataB, 32'h0000_BEEF);
`else
        #1 chk("same_cycle", readDataB, 32'h0000_0001);
`endif
        drive(5'd0, 32'd0, 1'b0, 5'd0, 5'd9);
        #1 chk("after_edge9", readDataB, 32'h0000_BEEF);

        // Reset during a write cycle leaves the target at zero.
        drive(5'd10, 32'h0000_0077, 1'b1, 5'd0, 5'd0);
        #1 resetN = 1'b0;
        @(negedge clk);
        #2 resetN = 1'b1;
        drive(5'd0, 32'd0, 1'b0, 5'd10, 5'd9);
        #1 chk("reset_mid_write", readDataA, 32'd0);
        chk("reset_cleared9", readDataB, 32'd0);

        // Sweep: reg N <- N+1, then read back on both ports.
        for (int a = 0; a < 32; a++) drive(5'(a), 32'(a + 1), 1'b1, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            drive(5'd0, 32'd0, 1'b0, 5'(a), 5'(31 - a));
            #1 chk("sweep_a", readDataA, (a == 0) ? 32'd0 : 32'(a + 1));
            chk("sweep_b", readDataB, (a == 31) ? 32'd0 : 32'(32 - a));
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int k = 0; k < 3000; k++) begin
            wa = 5'($urandom_range(0, 31));
            drive(wa, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) begin
                #1 resetN = 1'b0;
                @(negedge clk);
                #2 resetN = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
